// File: rtl/card_select_input.sv
// Player-input front end: syncs/debounces board buttons, moves a 4x4 cursor, emits card selections.
// Latency: DEBOUNCE_CYCLES + 3 clk from raw button edge to cursor/carta_El update.
// Backpressure: none; events arriving while en=0, in state TWO, or losing arbitration are dropped.
//
// Ports:
//   clk, rst (async, active-low)       - clock / reset
//   en                                 - card-play phase; press events discarded while low
//   btn_up/down/left/right/sel         - raw active-low buttons, asynchronous to clk
//   card_disabled[15:0]                - bit i set: card i already matched, not selectable
//   clear_sel                          - pair evaluated, return selection count to 0
//   cursor[3:0]                        - row*4 + col
//   carta_El                           - one-cycle pulse per accepted selection
//   card_idx[3:0], first_idx[3:0]      - last selected card / first card of current pair
//   cartas_sel[1:0]                    - cards selected in current pair (0..2)
//
// Build option: define CURSOR_WRAP_EN to make cursor moves wrap within the row/column;
// otherwise a move past the grid edge leaves the cursor unchanged.

module card_select_input #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_sel,
   input  logic [15:0] card_disabled,
   input  logic        clear_sel,
   output logic [3:0]  cursor,
   output logic        carta_El,
   output logic [3:0]  card_idx,
   output logic [3:0]  first_idx,
   output logic [1:0]  cartas_sel
);

   // Button slot order doubles as arbitration priority (lowest index wins).
   localparam int NB    = 5;
   localparam int B_SEL = 0;
   localparam int B_UP  = 1;
   localparam int B_DN  = 2;
   localparam int B_LT  = 3;
   localparam int B_RT  = 4;

   // Counter only needs to reach DEBOUNCE_CYCLES-1: the level flips on the edge
   // that would have completed the count.
   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ONE  = 2'd1,
      S_TWO  = 2'd2
   } sel_state_t;

   logic [NB-1:0] raw;
   logic [NB-1:0] sync1_q, sync2_q;
   logic [NB-1:0] deb_q, deb_d1_q;
   logic [NB-1:0] evt_q;
   logic [NB-1:0] act;
   logic [CW-1:0] cnt_q [NB];

   sel_state_t state_q, state_d;
   logic [3:0] cursor_q, cursor_d;
   logic [3:0] card_q, card_d;
   logic [3:0] first_q, first_d;
   logic       el_q, el_d;
   logic [1:0] row, col;
   logic       cur_ok;

   assign raw = {btn_right, btn_left, btn_down, btn_up, btn_sel};

   // ---------------- input conditioning ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         deb_q    <= '1;
         deb_d1_q <= '1;
         evt_q    <= '0;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         deb_d1_q <= deb_q;
         // Press = debounced 1->0; release produces nothing.
         evt_q    <= deb_d1_q & ~deb_q;
         for (int i = 0; i < NB; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               cnt_q[i] <= '0;
               deb_q[i] <= sync2_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign act = en ? evt_q : '0;

   // ---------------- cursor + selection FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cursor_q <= '0;
         card_q   <= '0;
         first_q  <= '0;
         el_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         card_q   <= card_d;
         first_q  <= first_d;
         el_q     <= el_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      card_d   = card_q;
      first_d  = first_q;
      el_d     = 1'b0;
      row      = cursor_q[3:2];
      col      = cursor_q[1:0];
      cur_ok   = !card_disabled[cursor_q];

      // A sel event still consumes the cycle's single action slot even when
      // clear_sel drops it, so lower-priority moves stay dropped too.
      if (act[B_SEL]) begin
         if (!clear_sel) begin
            case (state_q)
               S_IDLE: if (cur_ok) begin
                  el_d    = 1'b1;
                  card_d  = cursor_q;
                  first_d = cursor_q;
                  state_d = S_ONE;
               end
               S_ONE: if (cur_ok && (cursor_q != first_q)) begin
                  el_d    = 1'b1;
                  card_d  = cursor_q;
                  state_d = S_TWO;
               end
               default: ;
            endcase
         end
      end else if (act[B_UP]) begin
`ifdef CURSOR_WRAP_EN
         cursor_d = {row - 2'd1, col};
`else
         if (row != 2'd0) cursor_d = {row - 2'd1, col};
`endif
      end else if (act[B_DN]) begin
`ifdef CURSOR_WRAP_EN
         cursor_d = {row + 2'd1, col};
`else
         if (row != 2'd3) cursor_d = {row + 2'd1, col};
`endif
      end else if (act[B_LT]) begin
`ifdef CURSOR_WRAP_EN
         cursor_d = {row, col - 2'd1};
`else
         if (col != 2'd0) cursor_d = {row, col - 2'd1};
`endif
      end else if (act[B_RT]) begin
`ifdef CURSOR_WRAP_EN
         cursor_d = {row, col + 2'd1};
`else
         if (col != 2'd3) cursor_d = {row, col + 2'd1};
`endif
      end

      if (clear_sel) state_d = S_IDLE;
   end

   assign cursor     = cursor_q;
   assign carta_El   = el_q;
   assign card_idx   = card_q;
   assign first_idx  = first_q;
   assign cartas_sel = state_q;

endmodule

// File: doc/card_select_input.md
# card_select_input

Player-input front end for the memory game: it turns the raw board push-buttons into the card-selection signals the game FSM consumes. Buttons are synchronised and debounced. Directional presses then move a cursor over the 4×4 card grid, and the select button produces a one-cycle `carta_El` pulse with the chosen card index and a running `cartas_sel` count (0–2). The block sits between the board KEY pins and the game FSM, in the same 50 MHz `clk` domain as the FSM.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new button level (20 ms at 50 MHz).

Ports:
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: asynchronous reset, active-low.
- `en`, in, 1: game is in the card-play phase; when low, all press events are discarded.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, `btn_sel`, in, 1 each: raw buttons, active-low, asynchronous to `clk`.
- `card_disabled`, in, 16: bit i = 1 means card i is already matched and cannot be selected.
- `clear_sel`, in, 1: one-cycle pulse from the FSM when a pair has been evaluated; returns the count to 0.
- `cursor`, out, 4: current grid position, `row*4 + col`.
- `carta_El`, out, 1: one-cycle pulse on each accepted selection.
- `card_idx`, out, 4: index of the card just selected; valid while `carta_El` is high, then held.
- `first_idx`, out, 4: index of the first card of the current pair.
- `cartas_sel`, out, 2: number of cards selected in the current pair (0, 1 or 2).

## Operation
- **Input conditioning.**
  - Each button passes through a 2-flop synchroniser, then its own debounce counter.
  - The counter increments while the synchronised level differs from the debounced level and clears otherwise.
  - When it reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press event is a registered one-cycle pulse on the debounced high→low transition. A release generates no event.
- **Event arbitration.** At most one event is acted on per cycle. Priority: sel > up > down > left > right. Lower-priority events in the same cycle are dropped, not queued.
- **Cursor movement.**
  - up/down change the row by ∓1 (cursor ∓4).
  - left/right change the column by ∓1 (cursor ∓1).
  - Edge behaviour is set per Configuration.
  - The cursor moves regardless of `cartas_sel`, but only while `en` = 1.
- **Selection FSM.**
  - IDLE (`cartas_sel` = 0): sel at a cursor position with `card_disabled` = 0 → pulse `carta_El`, set `card_idx` and `first_idx` = cursor, go to ONE.
  - ONE (`cartas_sel` = 1): sel on an enabled card with cursor ≠ `first_idx` → pulse `carta_El`, set `card_idx` = cursor, go to TWO. A sel on `first_idx` or on a disabled card is silently rejected.
  - TWO (`cartas_sel` = 2): every sel is ignored until `clear_sel`.
  - `clear_sel` in any state → IDLE with `cartas_sel` = 0. `first_idx` and `card_idx` hold their values.
  - If `clear_sel` and a sel event occur in the same cycle, clear wins and the sel is dropped.
  - `en` falling does not change the state. Events are discarded while `en` is low.
- **Reset.** Asynchronous reset, active-low (`rst` = 0) forces:
  - `cursor` = 0, `carta_El` = 0, `card_idx` = 0, `first_idx` = 0, `cartas_sel` = 0, state IDLE.
  - Debounced levels = released (1), all debounce counters = 0, synchronisers = 1.
  - A reset during a debounce window discards the partial count.

## Timing
- Press latency: `carta_El` or the cursor update is visible `DEBOUNCE_CYCLES` + 3 rising edges after the first edge that samples the new raw level, provided the level stays stable. The 3 cycles are 2 synchroniser stages plus 1 registered event.
- Bounce: any return to the debounced level before the count completes restarts the window.
- All outputs are registered. `carta_El` is high for exactly 1 cycle per accepted selection.
- Holding a button gives exactly one event. A new event needs a debounced release followed by a new debounced press.

## Configuration
- `CURSOR_WRAP_EN` defined: moves wrap within the row or column.
  - left at col 0 → col 3; up at row 0 → row 3; and symmetrically for right and down.
- `CURSOR_WRAP_EN` undefined: moves past an edge saturate; the cursor is unchanged.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset, then a clean `btn_right` press held 20 cycles → `cursor` 0→1 exactly 7 cycles after the press; only one move.
- `btn_sel` bouncing (low 2, high 1, low 10 cycles) → a single `carta_El` 7 cycles after the final low; `card_idx` = `first_idx` = 0, `cartas_sel` = 1.
- Select card 5, then sel again on card 5, then on card 6 → second sel rejected; third gives `carta_El`, `card_idx` = 6, `cartas_sel` = 2. A further sel on card 7 is ignored.
- `card_disabled` = 16'h0001, sel at cursor 0 → no `carta_El`, `cartas_sel` stays 0. `clear_sel` coincident with a valid sel event → `cartas_sel` = 0, no pulse.
- Cursor 0, press left and up: with `CURSOR_WRAP_EN` defined → 3, then 15; without → remains 0. Up and left debounced in the same cycle → only the up move applied.
- `rst` asserted mid-debounce of `btn_down` and released → no move. A subsequent clean press takes the full 7 cycles.
